// File: rtl/fbs_pkg.sv
// Shared types and constants for the frame buffer scheduler.
// Optional statistics build: FBS_FRAME_STATS_EN.
package fbs_pkg;

  localparam int MAX_BUF = 8;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h8000_0000;
  localparam logic [31:0] DEF_BUF_STRIDE = 32'h0080_0000;

  typedef logic [2:0] slot_idx_t;

  typedef enum logic [2:0] {
    S_FREE    = 3'd0,
    S_QUEUED  = 3'd1,
    S_WRITING = 3'd2,
    S_READY   = 3'd3,
    S_READING = 3'd4
  } slot_st_e;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    PUSH
  } push_st_e;

  function automatic logic [31:0] slot_addr(
    input logic [31:0] base,
    input logic [31:0] stride,
    input slot_idx_t   idx
  );
    return base + stride * {29'd0, idx};
  endfunction

endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// DMA address FIFO / display reader bus of the frame buffer scheduler.
// Counter outputs exist only when FBS_FRAME_STATS_EN is defined.
interface frame_buffer_scheduler_if;

  logic        enable_i;
  logic        addr_fifo_full_i;
  logic        addr_fifo_wr_o;
  logic [31:0] addr_fifo_data_o;
  logic        frame_end_i;
  logic        rd_frame_req_i;
  logic [31:0] rd_addr_o;
  logic        rd_addr_valid_o;
  logic [2:0]  wr_slot_o;
  logic        wr_active_o;
`ifdef FBS_FRAME_STATS_EN
  logic [15:0] frame_cnt_o;
  logic [15:0] drop_cnt_o;
`endif

  modport slave (
`ifdef FBS_FRAME_STATS_EN
    output frame_cnt_o,
    output drop_cnt_o,
`endif
    input  enable_i,
    input  addr_fifo_full_i,
    input  frame_end_i,
    input  rd_frame_req_i,
    output addr_fifo_wr_o,
    output addr_fifo_data_o,
    output rd_addr_o,
    output rd_addr_valid_o,
    output wr_slot_o,
    output wr_active_o
  );

  modport master (
`ifdef FBS_FRAME_STATS_EN
    input  frame_cnt_o,
    input  drop_cnt_o,
`endif
    output enable_i,
    output addr_fifo_full_i,
    output frame_end_i,
    output rd_frame_req_i,
    input  addr_fifo_wr_o,
    input  addr_fifo_data_o,
    input  rd_addr_o,
    input  rd_addr_valid_o,
    input  wr_slot_o,
    input  wr_active_o
  );

endinterface

// File: rtl/fbs_free_slot_finder.sv
// Lowest-index FREE slot finder over the slot state table.
module fbs_free_slot_finder
  import fbs_pkg::*;
#(
  parameter int NUM_BUF = 4
) (
  input  slot_st_e  state_i [NUM_BUF],
  output logic      found_o,
  output slot_idx_t idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (state_i[i] == S_FREE) begin
        found_o = 1'b1;
        idx_o   = slot_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Frame buffer pool owner between capture DMA and display reader.
// Define FBS_FRAME_STATS_EN to add frame/drop counters.
module frame_buffer_scheduler
  import fbs_pkg::*;
#(
  parameter int          NUM_BUF    = 4,
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [31:0] BUF_STRIDE = DEF_BUF_STRIDE
) (
  input logic                      sys_clk_i,
  input logic                      rstn_i,
  frame_buffer_scheduler_if.slave  bus
);

  slot_st_e    slot_q [NUM_BUF];
  slot_st_e    slot_d [NUM_BUF];
  push_st_e    fsm_q;
  slot_idx_t   sel_q;
  logic [31:0] sel_addr_q;
  logic        fe_q;
  logic        fe_ev_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_addr_q;
  logic        rd_val_q;
  slot_idx_t   wr_slot_q;
  logic        wr_act_q;

  logic        free_found;
  slot_idx_t   free_idx;
  logic        q_found, w_found, rdy_found, rg_found;
  slot_idx_t   q_idx, w_idx, rdy_idx, rg_idx;
  logic        sel_free;
  logic        rd_take, fe_take, push_go, wr_after, drop;
  logic        wr_act_d;
  slot_idx_t   wr_slot_d;

  fbs_free_slot_finder #(
    .NUM_BUF (NUM_BUF)
  ) u_finder (
    .state_i (slot_q),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  // Every non-FREE state is held by at most one slot.
  always_comb begin
    q_found   = 1'b0;
    w_found   = 1'b0;
    rdy_found = 1'b0;
    rg_found  = 1'b0;
    q_idx     = '0;
    w_idx     = '0;
    rdy_idx   = '0;
    rg_idx    = '0;
    sel_free  = 1'b0;
    for (int i = 0; i < NUM_BUF; i++) begin
      case (slot_q[i])
        S_QUEUED:  begin q_found   = 1'b1; q_idx   = slot_idx_t'(i); end
        S_WRITING: begin w_found   = 1'b1; w_idx   = slot_idx_t'(i); end
        S_READY:   begin rdy_found = 1'b1; rdy_idx = slot_idx_t'(i); end
        S_READING: begin rg_found  = 1'b1; rg_idx  = slot_idx_t'(i); end
        default: ;
      endcase
      if (slot_idx_t'(i) == sel_q && slot_q[i] == S_FREE)
        sel_free = 1'b1;
    end
  end

  assign rd_take  = bus.rd_frame_req_i & rdy_found;
  assign fe_take  = fe_ev_q & w_found;
  assign drop     = fe_take & rdy_found & ~rd_take;
  assign push_go  = (fsm_q == PUSH) & ~bus.addr_fifo_full_i & sel_free;
  // DMA only stays busy across a frame end if a queued address follows.
  assign wr_after = fe_take ? q_found : w_found;

  always_comb begin
    for (int i = 0; i < NUM_BUF; i++) begin
      slot_d[i] = slot_q[i];
      if (rd_take && rg_found && rg_idx == slot_idx_t'(i))
        slot_d[i] = S_FREE;
      if (rd_take && rdy_idx == slot_idx_t'(i))
        slot_d[i] = S_READING;
      if (fe_take) begin
        if (w_idx == slot_idx_t'(i))
          slot_d[i] = S_READY;
        if (drop && rdy_idx == slot_idx_t'(i))
          slot_d[i] = S_FREE;
        if (q_found && q_idx == slot_idx_t'(i))
          slot_d[i] = S_WRITING;
      end
      if (push_go && sel_q == slot_idx_t'(i))
        slot_d[i] = wr_after ? S_QUEUED : S_WRITING;
    end
  end

  always_comb begin
    wr_act_d  = 1'b0;
    wr_slot_d = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (slot_d[i] == S_WRITING) begin
        wr_act_d  = 1'b1;
        wr_slot_d = slot_idx_t'(i);
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_BUF; i++)
        slot_q[i] <= S_FREE;
      fsm_q      <= IDLE;
      sel_q      <= '0;
      sel_addr_q <= '0;
      fe_q       <= 1'b0;
      fe_ev_q    <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      rd_addr_q  <= '0;
      rd_val_q   <= 1'b0;
      wr_slot_q  <= '0;
      wr_act_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BUF; i++)
        slot_q[i] <= slot_d[i];
      fe_q      <= bus.frame_end_i;
      fe_ev_q   <= bus.frame_end_i & ~fe_q;
      wr_q      <= 1'b0;
      wr_slot_q <= wr_slot_d;
      wr_act_q  <= wr_act_d;
      if (rd_take) begin
        rd_addr_q <= slot_addr(BASE_ADDR, BUF_STRIDE, rdy_idx);
        rd_val_q  <= 1'b1;
      end
      unique case (fsm_q)
        IDLE: begin
          if (bus.enable_i && !q_found && free_found &&
              !bus.addr_fifo_full_i)
            fsm_q <= SELECT;
        end
        SELECT: begin
          sel_q      <= free_idx;
          sel_addr_q <= slot_addr(BASE_ADDR, BUF_STRIDE, free_idx);
          fsm_q      <= PUSH;
        end
        PUSH: begin
          if (!bus.addr_fifo_full_i) begin
            fsm_q <= IDLE;
            if (sel_free) begin
              wr_q    <= 1'b1;
              wdata_q <= sel_addr_q;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

`ifdef FBS_FRAME_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (fe_take && frame_cnt_q != 16'hFFFF)
        frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.frame_cnt_o = frame_cnt_q;
  assign bus.drop_cnt_o  = drop_cnt_q;
`endif

  assign bus.addr_fifo_wr_o   = wr_q;
  assign bus.addr_fifo_data_o = wdata_q;
  assign bus.rd_addr_o        = rd_addr_q;
  assign bus.rd_addr_valid_o  = rd_val_q;
  assign bus.wr_slot_o        = wr_slot_q;
  assign bus.wr_active_o      = wr_act_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Self-checking bench for frame_buffer_scheduler with a 3-slot pool.
// Counter checks are compiled in when FBS_FRAME_STATS_EN is defined.
module tb_frame_buffer_scheduler;
  import fbs_pkg::*;

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h8080_0000;
  localparam logic [31:0] A2 = 32'h8100_0000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  frame_buffer_scheduler_if bus ();

  frame_buffer_scheduler #(
    .NUM_BUF    (3),
    .BASE_ADDR  (32'h8000_0000),
    .BUF_STRIDE (32'h0080_0000)
  ) dut (
    .sys_clk_i (clk),
    .rstn_i    (rstn),
    .bus       (bus)
  );

  int ntests = 0;
  int nfail  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the next predicted address.
  always @(negedge clk) begin
    if (rstn && bus.addr_fifo_wr_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL push_unexpected: got %h, expected no push",
                 bus.addr_fifo_data_o);
      end else begin
        chk("push_addr", bus.addr_fifo_data_o, exp_q.pop_front());
      end
    end
  end

  typedef enum {A_FE, A_RD, A_FE_RD} act_e;

  typedef struct {
    act_e        act;
    bit          push;
    logic [31:0] push_addr;
    logic [31:0] rd_addr;
    bit          rd_valid;
    bit          wr_act;
    logic [2:0]  wr_slot;
    int          drops;
    int          frames;
  } step_t;

  step_t steps [10];

  task automatic do_fe();
    bus.frame_end_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.frame_end_i = 1'b0;
  endtask

  task automatic do_rd();
    bus.rd_frame_req_i = 1'b1;
    @(negedge clk);
    bus.rd_frame_req_i = 1'b0;
  endtask

  // Read request lands on the cycle the registered frame-end event fires.
  task automatic do_fe_rd();
    bus.frame_end_i = 1'b1;
    @(negedge clk);
    bus.rd_frame_req_i = 1'b1;
    @(negedge clk);
    bus.rd_frame_req_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.frame_end_i = 1'b0;
  endtask

  task automatic chk_outs(input string p, input logic [31:0] ra,
                          input bit rv, input bit wa,
                          input logic [2:0] ws);
    chk({p, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({p, "_rd_addr"}, bus.rd_addr_o, ra);
    chk({p, "_rd_valid"}, 32'(bus.rd_addr_valid_o), 32'(rv));
    chk({p, "_wr_active"}, 32'(bus.wr_active_o), 32'(wa));
    chk({p, "_wr_slot"}, 32'(bus.wr_slot_o), 32'(ws));
  endtask

  initial begin
    int k;
    int strobes;

    bus.enable_i         = 1'b0;
    bus.addr_fifo_full_i = 1'b0;
    bus.frame_end_i      = 1'b0;
    bus.rd_frame_req_i   = 1'b0;

    steps[0] = '{A_FE,    1, A2, 32'h0, 0, 1, 3'd1, 0, 1};
    steps[1] = '{A_RD,    0, 0,  A0,    1, 1, 3'd1, 0, 1};
    steps[2] = '{A_RD,    0, 0,  A0,    1, 1, 3'd1, 0, 1};
    steps[3] = '{A_FE,    0, 0,  A0,    1, 1, 3'd2, 0, 2};
    steps[4] = '{A_FE,    1, A1, A0,    1, 1, 3'd1, 1, 3};
    steps[5] = '{A_FE,    1, A2, A0,    1, 1, 3'd2, 2, 4};
    steps[6] = '{A_RD,    1, A0, A1,    1, 1, 3'd2, 2, 4};
    steps[7] = '{A_FE,    0, 0,  A1,    1, 1, 3'd0, 2, 5};
    steps[8] = '{A_FE_RD, 1, A1, A2,    1, 1, 3'd1, 2, 6};
    steps[9] = '{A_RD,    1, A2, A0,    1, 1, 3'd1, 2, 6};

    repeat (3) @(negedge clk);
    chk("reset_wr", 32'(bus.addr_fifo_wr_o), 32'd0);
    chk("reset_data", bus.addr_fifo_data_o, 32'd0);
    chk_outs("reset", 32'h0, 0, 0, 3'd0);

    exp_q.push_back(A0);
    exp_q.push_back(A1);
    rstn         = 1'b1;
    bus.enable_i = 1'b1;
    repeat (15) @(negedge clk);
    chk_outs("startup", 32'h0, 0, 1, 3'd0);

    for (int i = 0; i < 10; i++) begin
      if (steps[i].push) exp_q.push_back(steps[i].push_addr);
      unique case (steps[i].act)
        A_FE:    do_fe();
        A_RD:    do_rd();
        A_FE_RD: do_fe_rd();
        default: ;
      endcase
      repeat (12) @(negedge clk);
      chk_outs($sformatf("step%0d", i), steps[i].rd_addr,
               steps[i].rd_valid, steps[i].wr_act, steps[i].wr_slot);
`ifdef FBS_FRAME_STATS_EN
      chk($sformatf("step%0d_frames", i), 32'(bus.frame_cnt_o),
          32'(steps[i].frames));
      chk($sformatf("step%0d_drops", i), 32'(bus.drop_cnt_o),
          32'(steps[i].drops));
`endif
    end

    // Pool exhausted: a frame end alone must not push.
    do_fe();
    repeat (12) @(negedge clk);
    chk_outs("exhaust", A0, 1, 1, 3'd2);

    // Read frees slot 0; push must follow within a few cycles.
    exp_q.push_back(A0);
    bus.rd_frame_req_i = 1'b1;
    k = 99;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.rd_frame_req_i = 1'b0;
      if (k == 99 && bus.addr_fifo_wr_o === 1'b1) k = c;
    end
    chk("free_push_latency", 32'(k <= 5), 32'd1);
    repeat (4) @(negedge clk);
    chk_outs("freed", A1, 1, 1, 3'd2);

    // FIFO full stall with enable dropped mid-push.
    do_fe();
    repeat (12) @(negedge clk);
    chk_outs("pre_stall", A1, 1, 1, 3'd0);
    exp_q.push_back(A1);
    bus.rd_frame_req_i = 1'b1;
    @(negedge clk);
    bus.rd_frame_req_i = 1'b0;
    @(negedge clk);
    bus.addr_fifo_full_i = 1'b1;
    bus.enable_i         = 1'b0;
    strobes = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.addr_fifo_wr_o === 1'b1) strobes++;
    end
    chk("stall_no_strobe", 32'(strobes), 32'd0);
    bus.addr_fifo_full_i = 1'b0;
    strobes = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.addr_fifo_wr_o === 1'b1) strobes++;
    end
    chk("stall_one_strobe", 32'(strobes), 32'd1);
    chk_outs("post_stall", A2, 1, 1, 3'd0);

    // Asynchronous reset in the middle of a frame-end pulse.
    bus.enable_i    = 1'b1;
    bus.frame_end_i = 1'b1;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_wr", 32'(bus.addr_fifo_wr_o), 32'd0);
    chk("rst_mid_data", bus.addr_fifo_data_o, 32'd0);
    chk_outs("rst_mid", 32'h0, 0, 0, 3'd0);
`ifdef FBS_FRAME_STATS_EN
    chk("rst_mid_frames", 32'(bus.frame_cnt_o), 32'd0);
    chk("rst_mid_drops", 32'(bus.drop_cnt_o), 32'd0);
`endif
    bus.frame_end_i = 1'b0;
    exp_q.delete();
    exp_q.push_back(A0);
    exp_q.push_back(A1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    chk_outs("restart", 32'h0, 0, 1, 3'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
- Owns the DDR frame-buffer pool shared by the capture DMA (writer) and the display reader.
- Pushes buffer base addresses into the capture DMA's address FIFO and retires buffers on the DMA's frame-end interrupt.
- Hands the newest complete buffer to the reader on request, so the writer never overwrites the buffer being displayed.
- Sits between the address FIFO write side and the display read-address register, in the `sys_clk_i` domain.

Parameters:
- `NUM_BUF`, 4, number of buffer slots (2..8).
- `BASE_ADDR`, 32'h8000_0000, DDR address of slot 0.
- `BUF_STRIDE`, 32'h0080_0000, byte distance between slots.

Ports:
- `sys_clk_i` in 1: single clock.
- `rstn_i` in 1: reset. Asynchronous, active-low (already decided).
- `enable_i` in 1: level; 0 inhibits new pushes; slots already issued still retire.
- `addr_fifo_full_i` in 1: DMA address FIFO full.
- `addr_fifo_wr_o` out 1: one-cycle FIFO write strobe.
- `addr_fifo_data_o` out 32: slot base address, valid with the strobe.
- `frame_end_i` in 1: DMA frame-end interrupt, a 4-cycle pulse.
- `rd_frame_req_i` in 1: one-cycle pulse from the reader at each display frame start.
- `rd_addr_o` out 32: base address of the slot being read.
- `rd_addr_valid_o` out 1: `rd_addr_o` holds a completed frame.
- `wr_slot_o` out 3: index of the slot being written.
- `wr_active_o` out 1: a slot is in WRITING.

Behaviour:
- Slot states: FREE, QUEUED, WRITING, READY, READING.
- At most one slot is in each state except FREE.
- Reset (also mid-operation): all slots FREE, FSM in IDLE, all outputs 0.
- Frame-end event = rising edge of `frame_end_i` (registered edge detect). Exactly one event per 4-cycle pulse; one cycle of latency after the edge.
- Push FSM:
  - IDLE: go to SELECT when all hold: `enable_i`=1, no QUEUED slot, a FREE slot exists, `addr_fifo_full_i`=0.
  - SELECT: latch the lowest-index FREE slot; compute address = `BASE_ADDR` + idx*`BUF_STRIDE` (32-bit, modulo 2^32).
  - PUSH: if `addr_fifo_full_i`=1, stall in PUSH. Otherwise:
    - Assert `addr_fifo_wr_o` for one cycle.
    - Slot becomes WRITING if no WRITING slot exists (DMA idle pops immediately), else QUEUED.
    - Return to IDLE.
  - Push latency: 2 cycles from the IDLE condition to the strobe.
- Frame-end event updates, all in one cycle:
  - WRITING slot → READY.
  - The previous READY slot → FREE, unless it is taken by a same-cycle read request.
  - QUEUED slot → WRITING.
  - If there is no QUEUED slot, nothing is WRITING and `wr_active_o`=0. The DMA is idle until the next push.
- Frame-end with no WRITING slot: ignored (spurious).
- Read request:
  - If a READY slot exists: it → READING; the previous READING slot → FREE; `rd_addr_o` is updated the next cycle and `rd_addr_valid_o`=1.
  - Otherwise: the current READING slot is held (frame repeat), `rd_addr_o` unchanged.
- Simultaneous frame-end and read request: the read takes the READY slot as it was before the update. The slot just completed becomes the new READY.
- Pool exhaustion: no FREE slot → no push. The push happens as soon as a read request frees a slot.
- SELECT with a slot freed or claimed that same cycle: the selection uses registered state, and the FSM re-checks in PUSH.
- `enable_i` deassert mid-PUSH: the push completes.

Optional Feature:
- Macro `FBS_FRAME_STATS_EN` adds outputs `frame_cnt_o` [15:0] and `drop_cnt_o` [15:0].
  - `frame_cnt_o` increments on each valid frame-end event.
  - `drop_cnt_o` increments when a READY slot is freed without ever being read.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package `fbs_pkg`:
  - slot-state encoding FREE=0, QUEUED=1, WRITING=2, READY=3, READING=4;
  - FSM encoding IDLE, SELECT, PUSH;
  - `MAX_BUF`=8 and the default `BASE_ADDR`/`BUF_STRIDE` constants.
- Sub-module `fbs_free_slot_finder`: combinational lowest-index FREE finder over `NUM_BUF` state entries; outputs `found` and `idx`.

Test Plan:
- Startup: reset, `enable_i`=1 → strobe with data 32'h8000_0000 (slot 0 WRITING), then 32'h8080_0000 (slot 1 QUEUED); no third push.
- Frame end: 4-cycle `frame_end_i` → slot 0 READY, slot 1 WRITING, then a push of 32'h8100_0000; exactly one event per pulse.
- Read: `rd_frame_req_i` after the first frame end → `rd_addr_o`=32'h8000_0000 and `rd_addr_valid_o`=1 next cycle. A second request with no new READY slot → address held.
- Exhaustion: `NUM_BUF`=3, reader idle, 3 frame ends → no push while no slot is FREE. A read request frees a slot → push within 3 cycles. `drop_cnt_o` counts the overwritten READY slots.
- Simultaneous events: frame end and read request in the same cycle → reader gets the old READY address; the new READY is the slot just completed.
- Stall and reset: `addr_fifo_full_i`=1 during PUSH holds the strobe off. Release → single strobe. `rstn_i` pulsed mid-frame → all outputs 0 and a restart from slot 0.
